mor1kx_icache_refill_wb: RTL and testbench
==========================================

Name: mor1kx_icache_refill_wb

Overview:
- Refill engine directly upstream of the instruction cache.
- Converts the cache's refill request into one Wishbone B3 wrapping burst that starts at the missed word (critical word first).
- Returns each word to the cache's refill write port (wradr/wrdat/we) in wrap order.
- Reports bus errors so the cache and fetch stage abort the refill.

Parameters:
- OPTION_OPERAND_WIDTH, 32, data/address width.
- OPTION_ICACHE_BLOCK_WIDTH, 5, log2 line bytes; only 4 (4 beats) and 5 (8 beats) are legal.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- refill_req_i  in  1  cache requests or is in refill
- refill_adr_i  in  32  missed fetch address (cpu_adr_match)
- wradr_o  out  32  refill word address to cache
- wrdat_o  out  32  refill word data to cache
- we_o  out  1  refill word valid, one cycle per word
- err_o  out  1  bus error pulse (feeds ic_imem_err)
- busy_o  out  1  engine not idle
- wbm_adr_o  out  32  bus address
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  bus strobe
- wbm_cti_o  out  3  cycle type
- wbm_bte_o  out  2  burst type
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  ack
- wbm_err_i  in  1  error

Behaviour:
- Reset values: all outputs 0; state IDLE; beat counter 0.
- States: IDLE, BURST, HOLD.
- IDLE -> BURST when refill_req_i=1.
  - Same edge: latch {refill_adr_i[31:2],2'b00} into wbm_adr_o.
  - Same edge: assert cyc/stb; load beat counter = beats-1 (7 or 3).
  - Latency: cyc/stb high the cycle after the request is seen.
- BURST:
  - wbm_bte_o = 2'b10 (8-beat wrap) for BLOCK_WIDTH 5, 2'b01 (4-beat wrap) for 4.
  - wbm_cti_o = 3'b010 while counter != 0, 3'b111 on the last beat.
  - On each wbm_ack_i: wbm_adr_o[BW-1:2] increments modulo beats; upper bits are held.
  - On each wbm_ack_i: next cycle we_o=1, wradr_o = address acked, wrdat_o = wbm_dat_i captured.
  - On each wbm_ack_i: counter decrements.
  - Ack while counter==0: drop cyc/stb/cti same edge, go HOLD.
- HOLD: exactly one cycle, refill_req_i ignored, then IDLE. This covers the cache's one-cycle lag in dropping refill_req after the final write.
- we_o is never high two cycles after the final word. Exactly `beats` we_o pulses per successful refill, in wrap order starting at the missed word.
- wbm_err_i in BURST (ack and err both high is treated as err):
  - Drop cyc/stb same edge; no we_o for that beat.
  - err_o=1 for one cycle; go HOLD.
  - Words already written stay written. The cache's refill_valid tracking makes them harmless.
- wbm_ack_i/wbm_err_i outside BURST: ignored.
- refill_req_i dropping mid-BURST: the burst still completes. The bus is never abandoned except on err/rst.
- rst mid-burst: cyc/stb/we_o/err_o are 0 from the next cycle.
- busy_o = state != IDLE.

Optional Feature:
- Macro MOR1KX_ICACHE_REFILL_CLASSIC_EN.
- Defined:
  - Classic single reads only: cti=3'b000, bte=2'b00.
  - stb/cyc deassert for one cycle after each ack, then reassert with the next wrapped address.
  - Same beat count, order and we_o semantics.
- Undefined: wrapping burst as above.

Decomposition:
- Shared package/defines:
  - CTI constants: CLASSIC 3'b000, INC 3'b010, EOB 3'b111.
  - BTE constants: LINEAR 2'b00, WRAP4 2'b01, WRAP8 2'b10.
  - State encodings.
- Sub-module mor1kx_wrap_adr_inc: wrap-incrementer, address + block width -> next address within the line. Reusable by the dcache refill.

Test Plan:
- Miss at 0x0000_1014, BW=5, ack every cycle:
  - wbm_adr sequence 0x14,0x18,0x1C,0x00,0x04,0x08,0x0C,0x10 (upper 0x1000).
  - cti 010×7 then 111; bte=10.
  - 8 we_o pulses with matching wradr_o/wrdat_o.
  - cyc low after beat 8; busy_o low 2 cycles later.
- BW=4, miss at 0x2008:
  - Addresses 0x2008,0x200C,0x2000,0x2004; bte=01; 4 we_o pulses.
- Random ack stalls (0-3 wait cycles): identical address/data order; we_o only on ack+1.
- wbm_err_i on beat 3 of 8:
  - Exactly 2 we_o pulses; err_o single pulse.
  - cyc drops same edge; returns IDLE after HOLD.
  - A new request then starts a fresh burst at its own address.
- refill_req_i held high through the last word: no second burst starts; the next burst only after IDLE with refill_req_i=1.
- rst asserted mid-burst at beat 4: all outputs 0 next cycle; a subsequent request restarts at the critical word.
- With MOR1KX_ICACHE_REFILL_CLASSIC_EN: same sequence as the first scenario, cti=000 throughout, stb low one cycle between beats.

Source files
------------

// File: rtl/mor1kx_icache_refill_wb_pkg.sv
// ============================================================================
// Module   : mor1kx_icache_refill_wb_pkg
// Brief    : Wishbone cycle-type/burst-type codes and refill FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mor1kx_icache_refill_wb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   // Burst type matching a cache line of 2**block_width bytes.
   function automatic logic [1:0] bte_for_block(input int block_width);
      return (block_width == 5) ? BTE_WRAP8 : BTE_WRAP4;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mor1kx_wrap_adr_inc.sv
// ============================================================================
// Module   : mor1kx_wrap_adr_inc
// Brief    : Next word address inside a cache line, wrapping at the line end.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mor1kx_wrap_adr_inc #(
   parameter int OPTION_OPERAND_WIDTH      = 32,
   parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
   input  logic [OPTION_OPERAND_WIDTH-1:0] adr_i,
   output logic [OPTION_OPERAND_WIDTH-1:0] next_adr_o
);

   localparam int IDX_W = OPTION_ICACHE_BLOCK_WIDTH - 2;

   logic [IDX_W-1:0] w_idx_inc;

   // Only the word index within the line advances; line and byte bits are kept.
   assign w_idx_inc  = adr_i[OPTION_ICACHE_BLOCK_WIDTH-1:2] + IDX_W'(1);
   assign next_adr_o = {adr_i[OPTION_OPERAND_WIDTH-1:OPTION_ICACHE_BLOCK_WIDTH],
                        w_idx_inc, adr_i[1:0]};

endmodule

`default_nettype wire

// File: rtl/mor1kx_icache_refill_wb.sv
// ============================================================================
// Module   : mor1kx_icache_refill_wb
// Brief    : Icache refill engine, critical-word-first Wishbone wrap burst.
//            MOR1KX_ICACHE_REFILL_CLASSIC_EN selects classic single reads.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mor1kx_icache_refill_wb
   import mor1kx_icache_refill_wb_pkg::*;
#(
   parameter int OPTION_OPERAND_WIDTH      = 32,
   parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            refill_req_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,
   output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
   output logic                            we_o,
   output logic                            err_o,
   output logic                            busy_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
   output logic                            wbm_cyc_o,
   output logic                            wbm_stb_o,
   output logic [2:0]                      wbm_cti_o,
   output logic [1:0]                      wbm_bte_o,
   input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
   input  logic                            wbm_ack_i,
   input  logic                            wbm_err_i
);

   localparam int         AW       = OPTION_OPERAND_WIDTH;
   localparam int         BEATS    = 1 << (OPTION_ICACHE_BLOCK_WIDTH - 2);
   localparam logic [2:0] LAST_CNT = 3'(BEATS - 1);

`ifdef MOR1KX_ICACHE_REFILL_CLASSIC_EN
   localparam logic [2:0] CTI_MID  = CTI_CLASSIC;
   localparam logic [2:0] CTI_LAST = CTI_CLASSIC;
   localparam logic [1:0] BTE_RUN  = BTE_LINEAR;
`else
   localparam logic [2:0] CTI_MID  = CTI_INC;
   localparam logic [2:0] CTI_LAST = CTI_EOB;
   localparam logic [1:0] BTE_RUN  = bte_for_block(OPTION_ICACHE_BLOCK_WIDTH);
`endif

   state_t         state_q, state_d;
   logic [2:0]     cnt_q, cnt_d;
   logic [AW-1:0]  adr_q, adr_d;
   logic           cyc_q, cyc_d;
   logic           stb_q, stb_d;
   logic [2:0]     cti_q, cti_d;
   logic [1:0]     bte_q, bte_d;
   logic           we_q, we_d;
   logic [AW-1:0]  wradr_q, wradr_d;
   logic [AW-1:0]  wrdat_q, wrdat_d;
   logic           err_q, err_d;

   logic [AW-1:0]  w_next_adr;
   logic           w_unused_adr_lsb;

   assign w_unused_adr_lsb = ^refill_adr_i[1:0];

   mor1kx_wrap_adr_inc #(
      .OPTION_OPERAND_WIDTH      (OPTION_OPERAND_WIDTH),
      .OPTION_ICACHE_BLOCK_WIDTH (OPTION_ICACHE_BLOCK_WIDTH)
   ) u_wrap_adr_inc (
      .adr_i      (adr_q),
      .next_adr_o (w_next_adr)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      cyc_d   = cyc_q;
      stb_d   = stb_q;
      cti_d   = cti_q;
      bte_d   = bte_q;
      we_d    = 1'b0;
      wradr_d = wradr_q;
      wrdat_d = wrdat_q;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (refill_req_i) begin
               state_d = ST_BURST;
               adr_d   = {refill_adr_i[AW-1:2], 2'b00};
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               cnt_d   = LAST_CNT;
               cti_d   = CTI_MID;
               bte_d   = BTE_RUN;
            end
         end

         ST_BURST: begin
            if (stb_q) begin
               // Error wins over a simultaneous ack: the beat is discarded.
               if (wbm_err_i) begin
                  cyc_d   = 1'b0;
                  stb_d   = 1'b0;
                  cti_d   = CTI_CLASSIC;
                  bte_d   = BTE_LINEAR;
                  err_d   = 1'b1;
                  state_d = ST_HOLD;
               end else if (wbm_ack_i) begin
                  we_d    = 1'b1;
                  wradr_d = adr_q;
                  wrdat_d = wbm_dat_i;
                  if (cnt_q == 3'd0) begin
                     cyc_d   = 1'b0;
                     stb_d   = 1'b0;
                     cti_d   = CTI_CLASSIC;
                     bte_d   = BTE_LINEAR;
                     state_d = ST_HOLD;
                  end else begin
                     adr_d = w_next_adr;
                     cnt_d = cnt_q - 3'd1;
                     cti_d = (cnt_q == 3'd1) ? CTI_LAST : CTI_MID;
`ifdef MOR1KX_ICACHE_REFILL_CLASSIC_EN
                     cyc_d = 1'b0;
                     stb_d = 1'b0;
`endif
                  end
               end
            end else begin
               // Classic mode idle gap between single reads.
               cyc_d = 1'b1;
               stb_d = 1'b1;
            end
         end

         ST_HOLD: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
         adr_q   <= '0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         cti_q   <= CTI_CLASSIC;
         bte_q   <= BTE_LINEAR;
         we_q    <= 1'b0;
         wradr_q <= '0;
         wrdat_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
         cti_q   <= cti_d;
         bte_q   <= bte_d;
         we_q    <= we_d;
         wradr_q <= wradr_d;
         wrdat_q <= wrdat_d;
         err_q   <= err_d;
      end
   end

   assign wradr_o   = wradr_q;
   assign wrdat_o   = wrdat_q;
   assign we_o      = we_q;
   assign err_o     = err_q;
   assign busy_o    = (state_q != ST_IDLE);
   assign wbm_adr_o = adr_q;
   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = stb_q;
   assign wbm_cti_o = cti_q;
   assign wbm_bte_o = bte_q;

endmodule

`default_nettype wire

// File: tb/tb_mor1kx_icache_refill_wb.sv
// ============================================================================
// Module   : tb_mor1kx_icache_refill_wb
// Brief    : Directed bench for the icache refill engine, 8- and 4-beat lines.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mor1kx_icache_refill_wb;

   typedef struct packed {
      logic              sel4;
      logic [31:0]       miss;
      logic [3:0]        nbeats;
      logic [0:7][31:0]  exp;
      logic              stall;
      logic [3:0]        err_beat;
      logic              hold;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req5, req4;
   logic [31:0] req_adr;
   logic [31:0] dat_i;
   logic        ack, err;
   logic        sel4;

   logic [31:0] wradr5, wrdat5, wbadr5, wradr4, wrdat4, wbadr4;
   logic        we5, err5, busy5, cyc5, stb5, we4, err4, busy4, cyc4, stb4;
   logic [2:0]  cti5, cti4;
   logic [1:0]  bte5, bte4;

   logic [31:0] o_wradr, o_wrdat, o_adr;
   logic        o_we, o_err, o_busy, o_cyc, o_stb;
   logic [2:0]  o_cti;
   logic [1:0]  o_bte;

   int errors = 0;
   int checks = 0;
   int we_cnt = 0;
   vec_t vecs [7];

   always #5 clk = ~clk;

   mor1kx_icache_refill_wb #(.OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(5)) dut_bw5 (
      .clk(clk), .rst(rst), .refill_req_i(req5), .refill_adr_i(req_adr),
      .wradr_o(wradr5), .wrdat_o(wrdat5), .we_o(we5), .err_o(err5), .busy_o(busy5),
      .wbm_adr_o(wbadr5), .wbm_cyc_o(cyc5), .wbm_stb_o(stb5), .wbm_cti_o(cti5),
      .wbm_bte_o(bte5), .wbm_dat_i(dat_i), .wbm_ack_i(ack), .wbm_err_i(err));

   mor1kx_icache_refill_wb #(.OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(4)) dut_bw4 (
      .clk(clk), .rst(rst), .refill_req_i(req4), .refill_adr_i(req_adr),
      .wradr_o(wradr4), .wrdat_o(wrdat4), .we_o(we4), .err_o(err4), .busy_o(busy4),
      .wbm_adr_o(wbadr4), .wbm_cyc_o(cyc4), .wbm_stb_o(stb4), .wbm_cti_o(cti4),
      .wbm_bte_o(bte4), .wbm_dat_i(dat_i), .wbm_ack_i(ack), .wbm_err_i(err));

   always_comb begin
      o_wradr = sel4 ? wradr4 : wradr5;
      o_wrdat = sel4 ? wrdat4 : wrdat5;
      o_adr   = sel4 ? wbadr4 : wbadr5;
      o_we    = sel4 ? we4    : we5;
      o_err   = sel4 ? err4   : err5;
      o_busy  = sel4 ? busy4  : busy5;
      o_cyc   = sel4 ? cyc4   : cyc5;
      o_stb   = sel4 ? stb4   : stb5;
      o_cti   = sel4 ? cti4   : cti5;
      o_bte   = sel4 ? bte4   : bte5;
   end

   always @(posedge clk) if (o_we) we_cnt <= we_cnt + 1;

   function automatic logic [31:0] dat_of(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   task automatic chk(input int idx, input int beat, input string nm,
                      input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL v%0d beat%0d %s: got %h expected %h", idx, beat, nm, act, expv);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int n, w, ebeat, base;
      bit got_err;
      logic [2:0] exp_cti;
      logic [1:0] exp_bte;
      n = int'(v.nbeats);
      ebeat = int'(v.err_beat);
      got_err = 1'b0;
      sel4 = v.sel4;
      base = we_cnt;
      req_adr = v.miss;
      if (v.sel4) req4 = 1'b1; else req5 = 1'b1;
      @(negedge clk);
      chk(idx, 0, "cyc_start", {31'd0, o_cyc}, 32'd1);
      chk(idx, 0, "busy_start", {31'd0, o_busy}, 32'd1);
      if (!v.hold) begin req4 = 1'b0; req5 = 1'b0; end
      for (int b = 0; b < n && !got_err; b++) begin
         w = v.stall ? int'($urandom_range(0, 3)) : 0;
         dat_i = 32'hBAD0_0000;
         for (int s = 0; s < w; s++) begin
            chk(idx, b, "stall_stb", {31'd0, o_stb}, 32'd1);
            chk(idx, b, "stall_adr", o_adr, v.exp[b]);
            @(negedge clk);
            chk(idx, b, "stall_we", {31'd0, o_we}, 32'd0);
         end
`ifdef MOR1KX_ICACHE_REFILL_CLASSIC_EN
         exp_cti = 3'b000;
         exp_bte = 2'b00;
`else
         exp_cti = (b == n - 1) ? 3'b111 : 3'b010;
         exp_bte = v.sel4 ? 2'b01 : 2'b10;
`endif
         chk(idx, b, "adr", o_adr, v.exp[b]);
         chk(idx, b, "cti", {29'd0, o_cti}, {29'd0, exp_cti});
         chk(idx, b, "bte", {30'd0, o_bte}, {30'd0, exp_bte});
         chk(idx, b, "stb", {31'd0, o_stb}, 32'd1);
         dat_i = dat_of(v.exp[b]);
         if (b == ebeat - 1) err = 1'b1; else ack = 1'b1;
         @(negedge clk);
         ack = 1'b0;
         err = 1'b0;
         if (b == ebeat - 1) begin
            got_err = 1'b1;
            chk(idx, b, "err_pulse", {31'd0, o_err}, 32'd1);
            chk(idx, b, "we_on_err", {31'd0, o_we}, 32'd0);
            chk(idx, b, "cyc_on_err", {31'd0, o_cyc}, 32'd0);
         end else begin
            chk(idx, b, "we", {31'd0, o_we}, 32'd1);
            chk(idx, b, "wradr", o_wradr, v.exp[b]);
            chk(idx, b, "wrdat", o_wrdat, dat_of(v.exp[b]));
            if (b == n - 1) begin
               chk(idx, b, "cyc_end", {31'd0, o_cyc}, 32'd0);
            end else begin
`ifdef MOR1KX_ICACHE_REFILL_CLASSIC_EN
               chk(idx, b, "stb_gap", {31'd0, o_stb}, 32'd0);
               @(negedge clk);
               chk(idx, b, "stb_back", {31'd0, o_stb}, 32'd1);
               chk(idx, b, "we_gap", {31'd0, o_we}, 32'd0);
`else
               chk(idx, b, "cyc_mid", {31'd0, o_cyc}, 32'd1);
`endif
            end
         end
      end
      chk(idx, n, "busy_hold", {31'd0, o_busy}, 32'd1);
      @(negedge clk);
      chk(idx, n, "busy_idle", {31'd0, o_busy}, 32'd0);
      chk(idx, n, "err_single", {31'd0, o_err}, 32'd0);
      chk(idx, n, "we_after", {31'd0, o_we}, 32'd0);
      req4 = 1'b0;
      req5 = 1'b0;
      @(negedge clk);
      chk(idx, n, "no_restart", {31'd0, o_cyc}, 32'd0);
      chk(idx, n, "we_count", 32'(we_cnt - base), (ebeat != 0) ? 32'(ebeat - 1) : 32'(n));
   endtask

   initial begin
      vecs[0] = '{sel4: 1'b0, miss: 32'h0000_1014, nbeats: 4'd8,
                  exp: {32'h1014, 32'h1018, 32'h101C, 32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010},
                  stall: 1'b0, err_beat: 4'd0, hold: 1'b0};
      vecs[1] = '{sel4: 1'b1, miss: 32'h0000_2008, nbeats: 4'd4,
                  exp: {32'h2008, 32'h200C, 32'h2000, 32'h2004, 32'h0, 32'h0, 32'h0, 32'h0},
                  stall: 1'b0, err_beat: 4'd0, hold: 1'b0};
      vecs[2] = '{sel4: 1'b0, miss: 32'h0000_40FE, nbeats: 4'd8,
                  exp: {32'h40FC, 32'h40E0, 32'h40E4, 32'h40E8, 32'h40EC, 32'h40F0, 32'h40F4, 32'h40F8},
                  stall: 1'b1, err_beat: 4'd0, hold: 1'b0};
      vecs[3] = '{sel4: 1'b0, miss: 32'h0000_1014, nbeats: 4'd8,
                  exp: {32'h1014, 32'h1018, 32'h101C, 32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010},
                  stall: 1'b0, err_beat: 4'd3, hold: 1'b0};
      vecs[4] = '{sel4: 1'b0, miss: 32'h0000_5008, nbeats: 4'd8,
                  exp: {32'h5008, 32'h500C, 32'h5010, 32'h5014, 32'h5018, 32'h501C, 32'h5000, 32'h5004},
                  stall: 1'b0, err_beat: 4'd0, hold: 1'b1};
      vecs[5] = '{sel4: 1'b1, miss: 32'h0000_600C, nbeats: 4'd4,
                  exp: {32'h600C, 32'h6000, 32'h6004, 32'h6008, 32'h0, 32'h0, 32'h0, 32'h0},
                  stall: 1'b1, err_beat: 4'd0, hold: 1'b0};
      vecs[6] = '{sel4: 1'b0, miss: 32'h0000_7018, nbeats: 4'd8,
                  exp: {32'h7018, 32'h701C, 32'h7000, 32'h7004, 32'h7008, 32'h700C, 32'h7010, 32'h7014},
                  stall: 1'b0, err_beat: 4'd0, hold: 1'b0};

      rst = 1'b1; req5 = 1'b0; req4 = 1'b0; req_adr = '0;
      dat_i = '0; ack = 1'b0; err = 1'b0; sel4 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk(-1, 0, "rst_cyc", {31'd0, cyc5}, 32'd0);
      chk(-1, 0, "rst_stb", {31'd0, stb5}, 32'd0);
      chk(-1, 0, "rst_we", {31'd0, we5}, 32'd0);
      chk(-1, 0, "rst_busy", {31'd0, busy5 | busy4}, 32'd0);
      chk(-1, 0, "rst_adr", wbadr5, 32'd0);
      chk(-1, 0, "rst_cti_bte", {27'd0, cti5, bte5}, 32'd0);

      // Stray ack/err while idle must be ignored.
      ack = 1'b1; err = 1'b1;
      @(negedge clk);
      ack = 1'b0; err = 1'b0;
      chk(-1, 0, "idle_ack_we", {31'd0, we5 | we4}, 32'd0);
      chk(-1, 0, "idle_ack_err", {31'd0, err5 | err4}, 32'd0);
      chk(-1, 0, "idle_ack_busy", {31'd0, busy5 | busy4}, 32'd0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Reset in the middle of an 8-beat burst, asserted on beat 4.
      sel4 = 1'b0;
      req_adr = vecs[6].miss;
      req5 = 1'b1;
      @(negedge clk);
      req5 = 1'b0;
      for (int b = 0; b < 3; b++) begin
         chk(7, b, "pre_rst_adr", o_adr, vecs[6].exp[b]);
         dat_i = dat_of(vecs[6].exp[b]);
         ack = 1'b1;
         @(negedge clk);
         ack = 1'b0;
`ifdef MOR1KX_ICACHE_REFILL_CLASSIC_EN
         @(negedge clk);
`endif
      end
      chk(7, 3, "pre_rst_adr", o_adr, vecs[6].exp[3]);
      rst = 1'b1;
      ack = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      ack = 1'b0;
      chk(7, 3, "mid_rst_cyc", {31'd0, o_cyc}, 32'd0);
      chk(7, 3, "mid_rst_stb", {31'd0, o_stb}, 32'd0);
      chk(7, 3, "mid_rst_we", {31'd0, o_we}, 32'd0);
      chk(7, 3, "mid_rst_err", {31'd0, o_err}, 32'd0);
      chk(7, 3, "mid_rst_busy", {31'd0, o_busy}, 32'd0);
      chk(7, 3, "mid_rst_adr", o_adr, 32'd0);
      run_vec(vecs[6], 6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
